pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard, forwarding and interrupt-sequencing controller for the 5-stage MIPS pipeline.
- Watches the ID, ID/EX, EX/MEM and MEM/WB register-address and control fields.
- Drives the PC/IFID hold, the IDEX bubble, the IFID flush and the ALU operand-forwarding selects.
- Schedules external IRQ entry so that the interrupt is taken only at a safe pipeline boundary.

Parameters:
AW, 5, register address width
WAIT_MAX, 8, cycles the IRQ may wait for a safe slot before a forced take

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
id_rs  in  AW  Rs of the instruction in ID
id_rt  in  AW  Rt of the instruction in ID
id_use_rs  in  1  ID instruction reads Rs
id_use_rt  in  1  ID instruction reads Rt
id_jump  in  1  ID instruction is J/JAL/JR/JALR
id_kernel  in  1  PC[31] of the ID instruction (supervisor mode)
idex_memrd  in  1  EX instruction is a load
idex_addrc  in  AW  EX destination register
exmem_regwr  in  1  MEM-stage register write enable
exmem_addrc  in  AW  MEM-stage destination register
memwb_regwr  in  1  WB-stage register write enable
memwb_addrc  in  AW  WB-stage destination register
ex_br_taken  in  1  branch resolved taken in EX
irq  in  1  external interrupt request, level
stall  out  1  hold PC and IFID
bubble  out  1  zero the IDEX control fields
flush_ifid  out  1  replace IFID with NOP
fwd_a  out  2  ALU A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  ALU B source, same encoding as fwd_a
irq_take  out  1  one-cycle pulse; Control selects the interrupt vector and saves PC to $26
irq_busy  out  1  the FSM is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE; wait_cnt=0.
  - All outputs are forced to 0 regardless of the inputs.
  - A reset mid-sequence abandons the pending IRQ.
- Forwarding is combinational:
  - Source match means regwr=1, addrc!=0 and addrc equals id_rs (for fwd_a) or id_rt (for fwd_b).
  - When both EX/MEM and MEM/WB match, EX/MEM wins (01).
  - A register address of 0 never forwards.
- Load-use hazard (combinational): luse = idex_memrd & idex_addrc!=0 & ((id_use_rs & idex_addrc==id_rs) | (id_use_rt & idex_addrc==id_rt)).
  - luse gives stall=1 and bubble=1. The hazard clears naturally after 1 cycle.
- Control hazards:
  - ex_br_taken gives flush_ifid=1 and bubble=1, with stall forced to 0. The branch has priority over luse.
  - id_jump (without ex_br_taken) gives flush_ifid=1 only.
- safe = !ex_br_taken & !luse & !id_jump.
- IRQ FSM, registered, 2-bit state:
  - IDLE: if irq & !id_kernel go to WAIT, wait_cnt=0.
  - WAIT: wait_cnt increments each cycle.
    - If safe, or wait_cnt==WAIT_MAX-1, go to TAKE.
    - If irq drops, return to IDLE with no take.
  - TAKE: for exactly 1 cycle, irq_take=1, flush_ifid=1 and bubble=1; stall is forced to 0. Next state is HOLD.
  - HOLD: remain until irq==0, then go to IDLE. A new request is not accepted while in HOLD.
  - irq while id_kernel=1 is ignored in IDLE; this is the kernel mask.
- irq_busy = (state != IDLE).
- wait_cnt is a $clog2(WAIT_MAX)+1-bit counter that saturates and never wraps.
- Simultaneous events:
  - TAKE coinciding with ex_br_taken still takes the IRQ. The branch target is lost by design; the saved PC comes from ID.
  - Forwarding outputs are independent of the FSM.

Optional Feature:
HAZ_PERF_EN
- When defined, adds two outputs, perf_stall[15:0] and perf_flush[15:0]:
  - perf_stall counts cycles with stall=1.
  - perf_flush counts cycles with flush_ifid=1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, the ports do not exist and no counter logic is generated.

Test Plan:
- Load-use: idex_memrd=1, idex_addrc=8, id_rs=8, id_use_rs=1 -> stall=1 and bubble=1 for that cycle; fwd_a=01 on the next cycle once the load is in MEM with exmem_addrc=8.
- Dual forward: exmem_addrc=memwb_addrc=9 with both regwr=1, id_rt=9 -> fwd_b=01. With exmem_regwr=0 -> fwd_b=10. With addrc=0 -> fwd_b=00.
- Branch plus luse in the same cycle -> flush_ifid=1, bubble=1, stall=0.
- IRQ with id_kernel=0, safe from the start -> WAIT then TAKE; irq_take high exactly 1 cycle, 2 cycles after irq rises; HOLD persists until irq=0.
- IRQ with id_jump held at 1 continuously, WAIT_MAX=8 -> forced TAKE after 8 WAIT cycles. Separately, irq with id_kernel=1 -> FSM stays IDLE, irq_busy=0.
- Assert reset in TAKE -> all outputs 0 asynchronously. After reset is released with irq=1, the sequence restarts from IDLE.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and IRQ-sequencing controller for the 5-stage MIPS pipeline.
// Decides stalls, bubbles and flushes, selects ALU operand forwarding, and
// takes an external IRQ only at a safe boundary (or forcibly after WAIT_MAX cycles).
// Optional build macro: HAZ_PERF_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned AW       = 5,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_jump,
  input  logic          id_kernel,
  input  logic          idex_memrd,
  input  logic [AW-1:0] idex_addrc,
  input  logic          exmem_regwr,
  input  logic [AW-1:0] exmem_addrc,
  input  logic          memwb_regwr,
  input  logic [AW-1:0] memwb_addrc,
  input  logic          ex_br_taken,
  input  logic          irq,
  output logic          stall,
  output logic          bubble,
  output logic          flush_ifid,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          irq_take,
  output logic          irq_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0]   perf_stall,
  output logic [15:0]   perf_flush
`endif
);

  localparam int unsigned CW = $clog2(WAIT_MAX) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_TAKE = 2'b10,
    S_HOLD = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic       luse;
  logic       safe;
  logic       in_take;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Load-use detection and the safe-slot condition for IRQ entry.
  always_comb begin
    luse = 1'b0;
    if (idex_memrd && (idex_addrc != '0)) begin
      luse = (id_use_rs && (idex_addrc == id_rs)) ||
             (id_use_rt && (idex_addrc == id_rt));
    end
    safe = !ex_br_taken && !luse && !id_jump;
  end

  // Operand forwarding; the younger EX/MEM result wins over MEM/WB, $0 never forwards.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (exmem_regwr && (exmem_addrc != '0) && (exmem_addrc == id_rs)) begin
      fwd_a_raw = 2'b01;
    end else if (memwb_regwr && (memwb_addrc != '0) && (memwb_addrc == id_rs)) begin
      fwd_a_raw = 2'b10;
    end
    if (exmem_regwr && (exmem_addrc != '0) && (exmem_addrc == id_rt)) begin
      fwd_b_raw = 2'b01;
    end else if (memwb_regwr && (memwb_addrc != '0) && (memwb_addrc == id_rt)) begin
      fwd_b_raw = 2'b10;
    end
  end

  // IRQ sequencer next state and saturating wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (irq && !id_kernel) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q != CNT_SAT) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
        // A withdrawn request is dropped before any take is considered.
        if (!irq) begin
          state_d = S_IDLE;
        end else if (safe || (wait_cnt_q == CNT_LAST)) begin
          state_d = S_TAKE;
        end
      end
      S_TAKE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!irq) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign in_take = (state_q == S_TAKE);

  // Pipeline control outputs; everything is held low while reset is asserted.
  always_comb begin
    stall      = 1'b0;
    bubble     = 1'b0;
    flush_ifid = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    irq_take   = 1'b0;
    irq_busy   = 1'b0;
    if (reset) begin
      // A taken branch or IRQ entry replaces the stalled instruction, so no hold.
      stall      = luse && !ex_br_taken && !in_take;
      bubble     = luse || ex_br_taken || in_take;
      flush_ifid = ex_br_taken || id_jump || in_take;
      fwd_a      = fwd_a_raw;
      fwd_b      = fwd_b_raw;
      irq_take   = in_take;
      irq_busy   = (state_q != S_IDLE);
    end
  end

`ifdef HAZ_PERF_EN
  logic [15:0] perf_stall_q, perf_flush_q;

  // Saturating cycle counters for stall and flush activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
      if (flush_ifid && (perf_flush_q != 16'hFFFF)) begin
        perf_flush_q <= perf_flush_q + 16'd1;
      end
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// hand-written IRQ sequences and randomized stimulus against a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW       = 5;
  localparam int unsigned WAIT_MAX = 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] id_rs, id_rt, idex_addrc, exmem_addrc, memwb_addrc;
  logic          id_use_rs, id_use_rt, id_jump, id_kernel, idex_memrd;
  logic          exmem_regwr, memwb_regwr, ex_br_taken, irq;
  logic          stall, bubble, flush_ifid, irq_take, irq_busy;
  logic [1:0]    fwd_a, fwd_b;

  int checks;
  int passes;

  pipeline_hazard_ctrl #(.AW(AW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump), .id_kernel(id_kernel),
    .idex_memrd(idex_memrd), .idex_addrc(idex_addrc),
    .exmem_regwr(exmem_regwr), .exmem_addrc(exmem_addrc),
    .memwb_regwr(memwb_regwr), .memwb_addrc(memwb_addrc),
    .ex_br_taken(ex_br_taken), .irq(irq),
    .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .irq_take(irq_take), .irq_busy(irq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the IRQ sequencer: plain flags plus a count of elapsed wait cycles.
  bit m_waiting, m_taking, m_holding;
  int m_waited;

  logic [8:0] obs;
  logic       obs_take, obs_busy;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [8:0] dut_vec();
    return {stall, bubble, flush_ifid, fwd_a, fwd_b, irq_take, irq_busy};
  endfunction

  function automatic bit model_luse();
    if (!idex_memrd || idex_addrc == 0) return 1'b0;
    return (id_use_rs && idex_addrc == id_rs) || (id_use_rt && idex_addrc == id_rt);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    if (exmem_regwr && exmem_addrc != 0 && exmem_addrc == src) return 2'b01;
    if (memwb_regwr && memwb_addrc != 0 && memwb_addrc == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [8:0] model_out();
    bit lu, st, bu, fl, busy;
    if (!reset) return 9'd0;
    lu   = model_luse();
    st   = lu && !ex_br_taken && !m_taking;
    bu   = lu || ex_br_taken || m_taking;
    fl   = ex_br_taken || id_jump || m_taking;
    busy = m_waiting || m_taking || m_holding;
    return {st, bu, fl, model_fwd(id_rs), model_fwd(id_rt), m_taking, busy};
  endfunction

  task automatic model_clear();
    m_waiting = 0; m_taking = 0; m_holding = 0; m_waited = 0;
  endtask

  task automatic model_advance();
    bit safe;
    safe = !ex_br_taken && !model_luse() && !id_jump;
    if (!reset) model_clear();
    else if (m_taking) begin
      m_taking = 0; m_holding = 1;
    end else if (m_holding) begin
      if (!irq) m_holding = 0;
    end else if (m_waiting) begin
      if (!irq) m_waiting = 0;
      else if (safe || m_waited == int'(WAIT_MAX) - 1) begin
        m_waiting = 0; m_taking = 1;
      end else m_waited++;
    end else if (irq && !id_kernel) begin
      m_waiting = 1; m_waited = 0;
    end
  endtask

  // One clock cycle: inputs already driven; check at negedge, then advance the model.
  task automatic step(input string name);
    if (!reset) model_clear();
    @(negedge clk);
    obs = dut_vec();
    check(name, int'(obs), int'(model_out()));
    obs_take = irq_take;
    obs_busy = irq_busy;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_jump = 0; id_kernel = 0;
    idex_memrd = 0; idex_addrc = '0; exmem_regwr = 0; exmem_addrc = '0;
    memwb_regwr = 0; memwb_addrc = '0; ex_br_taken = 0; irq = 0;
  endtask

  typedef struct packed {
    logic          br;
    logic          jump;
    logic          memrd;
    logic [AW-1:0] idex_a;
    logic          use_rs;
    logic [AW-1:0] rs;
    logic          use_rt;
    logic [AW-1:0] rt;
    logic          ex_wr;
    logic [AW-1:0] ex_a;
    logic          wb_wr;
    logic [AW-1:0] wb_a;
    logic          e_stall;
    logic          e_bubble;
    logic          e_flush;
    logic [1:0]    e_fa;
    logic [1:0]    e_fb;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  initial begin
    logic [5:0] take_bits, busy_bits;
    logic [2:0] take3;
    int waits;
    bit got, busy_seen;

    checks = 0;
    passes = 0;
    model_clear();
    obs_take = 0;
    obs_busy = 0;

    //          br jmp mrd idex ur  rs  ut  rt  ew  ea  ww  wa  st bu fl fa     fb
    vecs[0] = '{0, 0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 2'b00, 2'b00};
    vecs[1] = '{0, 0, 0, 5'd0, 1, 5'd8, 0, 5'd0, 1, 5'd8, 0, 5'd0, 0, 0, 0, 2'b01, 2'b00};
    vecs[2] = '{0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd9, 1, 5'd9, 1, 5'd9, 0, 0, 0, 2'b00, 2'b01};
    vecs[3] = '{0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0, 5'd9, 1, 5'd9, 0, 0, 0, 2'b00, 2'b10};
    vecs[4] = '{0, 0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 2'b00, 2'b00};
    vecs[5] = '{1, 0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 1, 1, 2'b00, 2'b00};
    vecs[6] = '{0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 2'b00, 2'b00};
    vecs[7] = '{0, 0, 1, 5'd6, 0, 5'd6, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00};
    vecs[8] = '{0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00};
    vecs[9] = '{0, 0, 0, 5'd0, 0, 5'd3, 0, 5'd4, 1, 5'd3, 1, 5'd4, 0, 0, 0, 2'b01, 2'b10};

    // Reset holds every output low even with active hazard/forward inputs.
    drive_idle();
    reset = 0;
    ex_br_taken = 1; id_jump = 1; exmem_regwr = 1; exmem_addrc = 5'd2; id_rs = 5'd2;
    #3;
    check("reset_outputs", int'(dut_vec()), 0);
    @(posedge clk); @(posedge clk); #1;
    drive_idle();
    reset = 1;
    step("post_reset_idle");

    // Directed combinational vectors.
    for (int i = 0; i < NVEC; i++) begin
      drive_idle();
      ex_br_taken = vecs[i].br;     id_jump = vecs[i].jump;
      idex_memrd = vecs[i].memrd;   idex_addrc = vecs[i].idex_a;
      id_use_rs = vecs[i].use_rs;   id_rs = vecs[i].rs;
      id_use_rt = vecs[i].use_rt;   id_rt = vecs[i].rt;
      exmem_regwr = vecs[i].ex_wr;  exmem_addrc = vecs[i].ex_a;
      memwb_regwr = vecs[i].wb_wr;  memwb_addrc = vecs[i].wb_a;
      @(negedge clk);
      check($sformatf("vec%0d", i), int'({stall, bubble, flush_ifid, fwd_a, fwd_b}),
            int'({vecs[i].e_stall, vecs[i].e_bubble, vecs[i].e_flush, vecs[i].e_fa, vecs[i].e_fb}));
      @(posedge clk); #1;
    end
    drive_idle();
    step("idle_after_vecs");

    // IRQ with a safe pipeline: take pulses exactly once, two cycles after irq rises.
    take_bits = '0; busy_bits = '0;
    irq = 1;
    for (int i = 0; i < 6; i++) begin
      step("irq_safe");
      take_bits[i] = obs_take;
      busy_bits[i] = obs_busy;
    end
    check("irq_take_pattern", int'(take_bits), 6'b000100);
    check("irq_busy_pattern", int'(busy_bits), 6'b111110);
    irq = 0;
    step("hold_release");
    check("hold_busy_until_edge", int'(obs_busy), 1);
    step("back_idle");
    check("idle_after_hold", int'(obs_busy), 0);

    // Jump held continuously: the take is forced after WAIT_MAX wait cycles.
    irq = 1; id_jump = 1; waits = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step("irq_jump");
      if (obs_take) got = 1;
      else if (obs_busy) waits++;
    end
    check("forced_take_seen", int'(got), 1);
    check("forced_wait_cycles", waits, int'(WAIT_MAX));
    drive_idle();
    step("jump_release");
    step("jump_idle");
    check("jump_idle_busy", int'(obs_busy), 0);

    // Kernel-mode instruction masks the request.
    irq = 1; id_kernel = 1; busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step("irq_kernel");
      busy_seen = busy_seen | obs_busy;
    end
    check("kernel_mask_busy", int'(busy_seen), 0);
    drive_idle();
    step("kernel_done");

    // Reset asserted during TAKE clears outputs at once; sequence restarts afterwards.
    irq = 1;
    step("pre_take0");
    step("pre_take1");
    @(negedge clk);
    check("take_before_reset", int'(irq_take), 1);
    #1 reset = 0;
    #1 check("async_reset_in_take", int'(dut_vec()), 0);
    model_clear();
    @(posedge clk); #1;
    reset = 1;
    take3 = '0;
    for (int i = 0; i < 3; i++) begin
      step("restart");
      take3[i] = obs_take;
    end
    check("restart_take_pattern", int'(take3), 3'b100);
    drive_idle();
    step("restart_hold_exit");
    step("restart_idle");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      id_rs       = AW'($urandom_range(0, 3));
      id_rt       = AW'($urandom_range(0, 3));
      idex_addrc  = AW'($urandom_range(0, 3));
      exmem_addrc = AW'($urandom_range(0, 3));
      memwb_addrc = AW'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      exmem_regwr = 1'($urandom_range(0, 1));
      memwb_regwr = 1'($urandom_range(0, 1));
      idex_memrd  = ($urandom_range(0, 2) == 0);
      id_jump     = ($urandom_range(0, 3) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      id_kernel   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      reset       = ($urandom_range(0, 63) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
